// File: rtl/tx_fire_scheduler.sv
// tx_fire_scheduler: paces shots of the transmit counter bank (load, fire, wait sent, wait PRI).
// Define TX_SCHED_WATCHDOG_EN to add a WAIT_SENT watchdog and the err_timeout output.
module tx_fire_scheduler #(
    parameter int NUM_CH     = 4,
    parameter int COUNT_BITS = 16,
    parameter int PRI_BITS   = 24,
    parameter int WD_CYCLES  = 65536,
    localparam int IDXW      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         arm,
    input  logic                         stop,
    input  logic [15:0]                  num_shots,
    input  logic [PRI_BITS-1:0]          pri_cycles,
    input  logic [NUM_CH-1:0]            ch_mask,
    input  logic                         delay_wr_en,
    input  logic [IDXW-1:0]              delay_wr_idx,
    input  logic [COUNT_BITS-1:0]        delay_wr_data,
    input  logic [NUM_CH-1:0]            ch_pulse_sent,
    output logic [NUM_CH*COUNT_BITS-1:0] ch_count,
    output logic [NUM_CH-1:0]            ch_in_use,
    output logic                         start_count,
    output logic                         upload_new_count,
    output logic                         busy,
    output logic                         shot_done,
    output logic [15:0]                  shots_fired,
    output logic                         err_overrun
`ifdef TX_SCHED_WATCHDOG_EN
    ,
    output logic                         err_timeout
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD0,
        S_LOAD1,
        S_FIRE,
        S_WSENT,
        S_WPRI,
        S_ABORT0,
        S_ABORT1
    } state_t;

    if (NUM_CH < 1 || WD_CYCLES < 2) begin : g_bad_cfg
        $error("tx_fire_scheduler: NUM_CH must be >= 1 and WD_CYCLES >= 2");
    end

    state_t state, state_n;

    logic [COUNT_BITS-1:0] dly_tab [NUM_CH];
    logic [15:0]           num_lat;
    logic [PRI_BITS-1:0]   pri_lat;
    logic [PRI_BITS-1:0]   pri_cnt;
    logic [PRI_BITS:0]     pri_ahead;
    logic                  stop_pend;
    logic                  all_sent;
    logic                  last_shot;
    logic                  pri_due;
    logic                  pri_late;
    logic                  pri_short;
    logic                  wd_hit;
    logic                  done_n;
    logic                  set_ovr;

    assign all_sent  = &ch_pulse_sent;
    assign last_shot = (num_lat != '0) && (shots_fired == num_lat);

    // Leave WAIT_PRI two cycles early so the LOAD pair ends exactly one PRI after FIRE.
    assign pri_ahead = {1'b0, pri_cnt} + (PRI_BITS+1)'(2);
    assign pri_due   = pri_ahead >= {1'b0, pri_lat};
    assign pri_late  = pri_ahead > {1'b0, pri_lat};
    assign pri_short = pri_lat < PRI_BITS'(4);

`ifdef TX_SCHED_WATCHDOG_EN
    localparam int WDW = $clog2(WD_CYCLES + 1);

    logic [WDW-1:0] wd_cnt;

    assign wd_hit = (state == S_WSENT) && (wd_cnt == WDW'(WD_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            wd_cnt      <= '0;
            err_timeout <= 1'b0;
        end else begin
            wd_cnt <= (state == S_WSENT) ? wd_cnt + WDW'(1) : '0;
            if (state == S_IDLE && arm)
                err_timeout <= 1'b0;
            else if (wd_hit && !all_sent)
                err_timeout <= 1'b1;
        end
    end
`else
    assign wd_hit = 1'b0;
`endif

    always_comb begin
        state_n = state;
        done_n  = 1'b0;
        set_ovr = 1'b0;
        unique case (state)
            S_IDLE:  if (arm) state_n = S_LOAD0;
            S_LOAD0: state_n = stop ? S_IDLE : S_LOAD1;
            S_LOAD1: state_n = stop ? S_IDLE : S_FIRE;
            S_FIRE:  state_n = S_WSENT;
            S_WSENT: begin
                if (all_sent) begin
                    done_n  = 1'b1;
                    state_n = (stop || stop_pend || last_shot) ? S_IDLE : S_WPRI;
                end else if (wd_hit) begin
                    state_n = S_ABORT0;
                end
            end
            S_WPRI: begin
                if (stop) begin
                    state_n = S_IDLE;
                end else if (pri_short || pri_late) begin
                    set_ovr = 1'b1;
                    state_n = S_LOAD0;
                end else if (pri_due) begin
                    state_n = S_LOAD0;
                end
            end
            S_ABORT0: state_n = S_ABORT1;
            S_ABORT1: state_n = S_IDLE;
            default:  state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            num_lat          <= '0;
            pri_lat          <= '0;
            ch_in_use        <= '0;
            pri_cnt          <= '0;
            stop_pend        <= 1'b0;
            shots_fired      <= '0;
            err_overrun      <= 1'b0;
            start_count      <= 1'b0;
            upload_new_count <= 1'b0;
            busy             <= 1'b0;
            shot_done        <= 1'b0;
        end else begin
            state            <= state_n;
            start_count      <= state_n == S_FIRE;
            upload_new_count <= state_n inside {S_LOAD0, S_LOAD1, S_ABORT0, S_ABORT1};
            busy             <= state_n != S_IDLE;
            shot_done        <= done_n;
            if (state == S_IDLE && arm) begin
                num_lat     <= num_shots;
                pri_lat     <= pri_cycles;
                ch_in_use   <= ch_mask;
                shots_fired <= '0;
                err_overrun <= 1'b0;
            end
            if (state_n == S_FIRE) begin
                pri_cnt     <= PRI_BITS'(1);
                shots_fired <= shots_fired + 16'd1;
            end else if (pri_cnt != '1) begin
                pri_cnt <= pri_cnt + PRI_BITS'(1);
            end
            if (set_ovr)
                err_overrun <= 1'b1;
            if ((state == S_FIRE || state == S_WSENT) && stop)
                stop_pend <= 1'b1;
            if (state_n == S_IDLE)
                stop_pend <= 1'b0;
        end
    end

    // Host writes land in the table; counters only see it at the next LOAD entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_CH; i++)
                dly_tab[i] <= '0;
            ch_count <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++)
                if (delay_wr_en && delay_wr_idx == IDXW'(i))
                    dly_tab[i] <= delay_wr_data;
            if (state != S_LOAD0 && state_n == S_LOAD0)
                for (int i = 0; i < NUM_CH; i++)
                    ch_count[i*COUNT_BITS +: COUNT_BITS] <= dly_tab[i];
        end
    end

endmodule

// File: tb/tb_tx_fire_scheduler.sv
// tb_tx_fire_scheduler: timeline model of shot/PRI rules, per-cycle compare,
// plus literal spot checks for delay buffering, overrun, stop and reset.
module tb_tx_fire_scheduler;

    localparam int NC  = 4;
    localparam int CB  = 16;
    localparam int PB  = 24;
    localparam int LEN = 600;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          arm = 1'b0;
    logic          stop = 1'b0;
    logic [15:0]   num_shots = '0;
    logic [PB-1:0] pri_cycles = '0;
    logic [NC-1:0] ch_mask = '0;
    logic          delay_wr_en = 1'b0;
    logic [1:0]    delay_wr_idx = '0;
    logic [CB-1:0] delay_wr_data = '0;
    logic [NC-1:0] sent = '0;

    logic [NC*CB-1:0] ch_count;
    logic [NC-1:0]    ch_in_use;
    logic             start_count;
    logic             upload_new_count;
    logic             busy;
    logic             shot_done;
    logic [15:0]      shots_fired;
    logic             err_overrun;
`ifdef TX_SCHED_WATCHDOG_EN
    logic             err_timeout;
`endif

    tx_fire_scheduler #(
        .NUM_CH(NC), .COUNT_BITS(CB), .PRI_BITS(PB), .WD_CYCLES(100)
    ) dut (
        .clk(clk), .rst(rst), .arm(arm), .stop(stop),
        .num_shots(num_shots), .pri_cycles(pri_cycles), .ch_mask(ch_mask),
        .delay_wr_en(delay_wr_en), .delay_wr_idx(delay_wr_idx),
        .delay_wr_data(delay_wr_data), .ch_pulse_sent(sent),
        .ch_count(ch_count), .ch_in_use(ch_in_use),
        .start_count(start_count), .upload_new_count(upload_new_count),
        .busy(busy), .shot_done(shot_done), .shots_fired(shots_fired),
        .err_overrun(err_overrun)
`ifdef TX_SCHED_WATCHDOG_EN
        , .err_timeout(err_timeout)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int t = 0;
    bit chk_en = 1'b0;
    int g_stop = -1;
    int g_rst = -1;
    int g_arm2 = -1;
    int g_wr = -1;
    int g_wr_data = 0;
    int fires[$];
    int dones[$];
    int cc2[LEN];

    bit          e_start[LEN];
    bit          e_up[LEN];
    bit          e_busy[LEN];
    bit          e_done[LEN];
    bit          e_ovr[LEN];
    int          e_shots[LEN];
    logic [3:0]  e_use[LEN];

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0d got=%0h exp=%0h", nm, t, act, exp);
        end
    endtask

    // Shot timeline: FIRE 3 cycles after arm; sent D cycles after FIRE gives
    // shot_done at FIRE+D+1; next FIRE at max(FIRE+P, shot_done+3).
    function automatic void build(int p, int d, int n, int stp, int len);
        int f, dn, nf, k, end_t, ovr_t;
        bit last;
        for (int i = 0; i < LEN; i++) begin
            e_start[i] = 0; e_up[i] = 0; e_busy[i] = 0;
            e_done[i] = 0; e_ovr[i] = 0; e_shots[i] = 0;
        end
        f = 3; k = 0; end_t = len; ovr_t = len;
        while (f - 2 < len) begin
            e_up[f-2] = 1;
            if (stp == f - 2) begin end_t = f - 1; break; end
            if (f - 1 < len) e_up[f-1] = 1;
            if (stp == f - 1) begin end_t = f; break; end
            if (f >= len) break;
            e_start[f] = 1;
            k++;
            dn = f + d + 1;
            last = (n != 0 && k == n) || (stp >= f && stp < dn);
            if (dn < len) e_done[dn] = 1;
            if (last) begin end_t = dn; break; end
            nf = (f + p > dn + 3) ? f + p : dn + 3;
            if (f + p < dn + 3 && ovr_t == len) ovr_t = dn + 1;
            if (stp >= dn && stp <= nf - 3) begin end_t = stp + 1; break; end
            f = nf;
        end
        for (int i = 1; i < len; i++) begin
            e_busy[i]  = i < end_t;
            e_shots[i] = e_shots[i-1] + int'(e_start[i]);
            e_ovr[i]   = i >= ovr_t;
        end
    endfunction

    always @(negedge clk) begin
        if (chk_en && t >= 1) begin
            chk("start_count", start_count, e_start[t]);
            chk("upload_new_count", upload_new_count, e_up[t]);
            chk("busy", busy, e_busy[t]);
            chk("shot_done", shot_done, e_done[t]);
            chk("shots_fired", shots_fired, e_shots[t]);
            chk("err_overrun", err_overrun, e_ovr[t]);
            chk("ch_in_use", ch_in_use, e_use[t]);
        end
    end

    task automatic run_seq(int p, int d, int n, int len, logic [3:0] mask);
        int sent_at;
        sent_at = -1;
        build(p, d, n, g_stop, len);
        for (int i = 0; i < len; i++) begin
            if (g_rst >= 0 && i > g_rst) begin
                e_start[i] = 0; e_up[i] = 0; e_busy[i] = 0;
                e_done[i] = 0; e_ovr[i] = 0; e_shots[i] = 0;
            end
            e_use[i] = (g_rst < 0 || i <= g_rst) ? mask : 4'h0;
        end
        fires.delete();
        dones.delete();
        for (int c = 0; c < len; c++) begin
            @(posedge clk); #1;
            t = c;
            chk_en = 1'b1;
            arm  = (c == 0) || (c == g_arm2);
            stop = (c == g_stop);
            rst  = (c == g_rst);
            if (c == 0) begin
                num_shots = 16'(n); pri_cycles = PB'(p); ch_mask = mask;
            end
            if (c == 1) begin
                num_shots = 16'd7; pri_cycles = PB'(3); ch_mask = 4'h0;
            end
            delay_wr_en   = (c == g_wr);
            delay_wr_idx  = 2'd2;
            delay_wr_data = CB'(g_wr_data);
            cc2[c] = int'(ch_count[47:32]);
            if (start_count) begin fires.push_back(c); sent_at = c + d; end
            if (shot_done) dones.push_back(c);
            if (upload_new_count || rst) sent = '0;
            if (rst) sent_at = -1;
            if (c == sent_at) sent = '1;
        end
        @(posedge clk); #1;
        chk_en = 1'b0; arm = 1'b0; stop = 1'b0; rst = 1'b0; delay_wr_en = 1'b0;
        g_stop = -1; g_rst = -1; g_arm2 = -1; g_wr = -1;
    endtask

    task automatic wr(int idx, int val);
        @(posedge clk); #1;
        delay_wr_en = 1'b1; delay_wr_idx = 2'(idx); delay_wr_data = CB'(val);
        @(posedge clk); #1;
        delay_wr_en = 1'b0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst busy", busy, 0);
        chk("rst start", start_count, 0);
        chk("rst upload", upload_new_count, 0);
        chk("rst shot_done", shot_done, 0);
        chk("rst shots", shots_fired, 0);
        chk("rst ovr", err_overrun, 0);
        chk("rst ch_count", ch_count, 0);
        chk("rst ch_in_use", ch_in_use, 0);

        wr(0, 5); wr(1, 10); wr(2, 15); wr(3, 20);

        // three shots, PRI 200, table write mid-shot, ignored re-arm
        g_wr = 100; g_wr_data = 99; g_arm2 = 100;
        run_seq(200, 50, 3, 470, 4'hF);
        chk("t1 fires", fires.size(), 3);
        chk("t1 gap1", (fires.size() >= 2) ? fires[1] - fires[0] : -1, 200);
        chk("t1 gap2", (fires.size() >= 3) ? fires[2] - fires[1] : -1, 200);
        chk("t1 dones", dones.size(), 3);
        chk("t1 shots", shots_fired, 3);
        chk("t1 busy", busy, 0);
        chk("t1 ovr", err_overrun, 0);
        chk("t2 shot1 cnt2", cc2[50], 15);
        chk("t2 pre-load cnt2", cc2[200], 15);
        chk("t2 load2 cnt2", cc2[201], 99);
        chk("t2 ch_count", ch_count, {16'd20, 16'd99, 16'd10, 16'd5});

        // overrun: PRI 30, reply after 50; stop with arm is ignored
        g_stop = 0;
        run_seq(30, 50, 2, 120, 4'b0101);
        chk("t3 ovr", err_overrun, 1);
        chk("t3 done0", (dones.size() >= 1) ? dones[0] : -1, 54);
        chk("t3 fire1", (fires.size() >= 2) ? fires[1] : -1, 57);
        chk("t3 shots", shots_fired, 2);

        // continuous mode stopped in WAIT_PRI after shot 4
        g_stop = 140;
        run_seq(40, 10, 0, 200, 4'hF);
        chk("t4 shots", shots_fired, 4);
        chk("t4 fires", fires.size(), 4);
        chk("t4 busy", busy, 0);

        // reset during WAIT_SENT, then a clean sequence
        g_rst = 30;
        run_seq(100, 60, 0, 36, 4'hF);
        chk("t5 ch_count", ch_count, 0);
        chk("t5 shots", shots_fired, 0);
        chk("t5 fires", fires.size(), 1);
        wr(0, 1); wr(1, 2); wr(2, 3); wr(3, 4);
        run_seq(50, 5, 2, 70, 4'h3);
        chk("t5b shots", shots_fired, 2);
        chk("t5b gap", (fires.size() >= 2) ? fires[1] - fires[0] : -1, 50);
        chk("t5b ch_count", ch_count, {16'd4, 16'd3, 16'd2, 16'd1});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
